// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg. The DUT uses the slave side and the
// upstream/downstream driver uses the master side.
interface pipe_skid_reg_if #(
    parameter int DW = 32
);
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [1:0]    count_o;

    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );

    modport master (
        output flush_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: a main entry and a skid entry. This keeps full throughput while
// in_ready_o remains a flop. Flush and empty slots read back as the NOP payload.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | nothing held, out_valid_o=0, count 0
// ST_BUSY  | main entry valid, count 1
// ST_FULL  | main and skid valid, count 2, input blocked
module pipe_skid_reg #(
    parameter int            DW  = 32,
    parameter logic [DW-1:0] NOP = DW'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    pipe_skid_reg_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic [DW-1:0] w_main_nxt;
    logic [DW-1:0] w_skid_nxt;
    logic          r_in_ready;
    logic          w_in_fire;
    logic          w_out_fire;

    assign w_in_fire  = bus.in_valid_i & r_in_ready;
    assign w_out_fire = (r_state != ST_EMPTY) & bus.out_ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_main     <= NOP;
            r_skid     <= NOP;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_nxt  = bus.in_data_i;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = bus.in_data_i;
                end else if (w_in_fire) begin
                    w_skid_nxt  = bus.in_data_i;
                    w_state_nxt = ST_FULL;
                end else if (w_out_fire) begin
                    w_main_nxt  = NOP;
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_main_nxt  = r_skid;
                    w_skid_nxt  = NOP;
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_main_nxt  = NOP;
                w_skid_nxt  = NOP;
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // A flush still lets the presented main entry complete downstream; only the held copies are dropped.
        if (bus.flush_i) begin
            w_main_nxt  = NOP;
            w_skid_nxt  = NOP;
            w_state_nxt = ST_EMPTY;
        end
    end

    always_comb begin
        bus.out_valid_o = (r_state != ST_EMPTY);
        bus.out_data_o  = r_main;
        bus.in_ready_o  = r_in_ready;
        bus.count_o     = r_state;
    end

endmodule
